realign_arb: RTL and testbench

Round-robin scheduler that shares one combinational `realign` normaliser among N dot-product lanes. Each lane offers an (exponent max, fixed-point mantissa sum) pair over a valid/ready handshake. The block registers the granted operand, drives the shared realign unit, and captures the packed 32-bit float into a tagged result register. One operation per cycle is sustained when the result consumer is ready.

---
 rtl/realign_arb.sv | 158 +++++++++++++++
 tb/tb_realign_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/realign_arb.sv
// realign_arb
//
// Round-robin scheduler sharing one combinational realign normaliser among
// N dot-product lanes. A granted lane's (exponent max, mantissa sum) pair is
// registered in stage A, which drives the shared realign unit. The unit's
// packed float result is captured together with the lane tag in stage B.
// With the result consumer ready, one operation per cycle is sustained.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   per-lane handshake; req_ready is one-hot or zero
//   req_e_max         lane i exponent at [i*E_W +: E_W]
//   req_m_sum         lane i mantissa sum at [i*M_X_W +: M_X_W]
//   rl_e_max/m_sum    operand presented to the shared realign unit
//   rl_out            realign result, combinational from rl_e_max/rl_m_sum
//   res_valid/ready   result handshake
//   res_data, res_id  packed result and the lane that issued it

module realign_arb #(
  parameter int N     = 4,
  parameter int E_W   = 8,
  parameter int M_X_W = 48,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*E_W-1:0]   req_e_max,
  input  logic [N*M_X_W-1:0] req_m_sum,
  output logic [E_W-1:0]     rl_e_max,
  output logic [M_X_W-1:0]   rl_m_sum,
  input  logic [31:0]        rl_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic [ID_W-1:0]    res_id
);

  localparam logic [ID_W:0]   N_EXT   = (ID_W+1)'(N);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N-1);

  logic               a_valid_q, a_valid_d;
  logic [ID_W-1:0]    a_id_q, a_id_d;
  logic [E_W-1:0]     a_e_max_q, a_e_max_d;
  logic [M_X_W-1:0]   a_m_sum_q, a_m_sum_d;
  logic               b_valid_q, b_valid_d;
  logic [ID_W-1:0]    b_id_q, b_id_d;
  logic [31:0]        b_data_q, b_data_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [2*N-1:0]     req_dbl;
  logic [N-1:0]       req_rot;
  logic               grant_any;
  logic [ID_W-1:0]    grant_off;
  logic [ID_W:0]      grant_sum;
  logic [ID_W-1:0]    grant_idx;
  logic               adv_b;
  logic               load_a;
  logic               grant;

  // Rotate the request vector so bit 0 is the lane at rr_ptr; the lowest set
  // bit of the rotated vector is then the circular-first requester. The
  // offset is mapped back to a lane number modulo N, which need not be a
  // power of two.
  always_comb begin
    req_dbl   = {req_valid, req_valid} >> rr_ptr_q;
    req_rot   = req_dbl[N-1:0];
    grant_any = 1'b0;
    grant_off = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_any = 1'b1;
        grant_off = ID_W'(k);
      end
    end
    grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
    if (grant_sum >= N_EXT) begin
      grant_sum = grant_sum - N_EXT;
    end
    grant_idx = grant_sum[ID_W-1:0];
  end

  // Pipeline advance conditions and the grant strobe. Stage A can take a new
  // operand when empty or when its current one moves into stage B.
  always_comb begin
    adv_b     = a_valid_q & (~b_valid_q | res_ready);
    load_a    = ~a_valid_q | adv_b;
    grant     = load_a & ~rst & grant_any;
    req_ready = grant ? (N'(1) << grant_idx) : '0;
  end

  // Next-state for both stages and the round-robin pointer. Stage A is
  // cleared to zero whenever it empties so the realign operand reads 0.
  always_comb begin
    a_valid_d = a_valid_q;
    a_id_d    = a_id_q;
    a_e_max_d = a_e_max_q;
    a_m_sum_d = a_m_sum_q;
    b_valid_d = b_valid_q;
    b_id_d    = b_id_q;
    b_data_d  = b_data_q;
    rr_ptr_d  = rr_ptr_q;

    if (load_a) begin
      if (grant) begin
        a_valid_d = 1'b1;
        a_id_d    = grant_idx;
        a_e_max_d = req_e_max[grant_idx*E_W +: E_W];
        a_m_sum_d = req_m_sum[grant_idx*M_X_W +: M_X_W];
        rr_ptr_d  = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
      end else begin
        a_valid_d = 1'b0;
        a_id_d    = '0;
        a_e_max_d = '0;
        a_m_sum_d = '0;
      end
    end

    if (adv_b) begin
      b_valid_d = 1'b1;
      b_id_d    = a_id_q;
      b_data_d  = rl_out;
    end else if (b_valid_q & res_ready) begin
      b_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_id_q    <= '0;
      a_e_max_q <= '0;
      a_m_sum_q <= '0;
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
      b_data_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_id_q    <= a_id_d;
      a_e_max_q <= a_e_max_d;
      a_m_sum_q <= a_m_sum_d;
      b_valid_q <= b_valid_d;
      b_id_q    <= b_id_d;
      b_data_q  <= b_data_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign rl_e_max  = a_e_max_q;
  assign rl_m_sum  = a_m_sum_q;
  assign res_valid = b_valid_q;
  assign res_data  = b_data_q;
  assign res_id    = b_id_q;

endmodule

// File: tb/tb_realign_arb.sv
// tb_realign_arb
//
// Drives a 4-lane realign_arb with directed and random traffic and compares
// it every cycle against a queue-based model of the two-slot pipeline and a
// modular-arithmetic round-robin pointer. A second 3-lane instance checks
// arbitration when N is not a power of two. The realign unit is stubbed as
// {e_max, m_sum[23:0]}.

module tb_realign_arb;

  localparam int N     = 4;
  localparam int E_W   = 8;
  localparam int M_X_W = 48;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*E_W-1:0]   req_e_max;
  logic [N*M_X_W-1:0] req_m_sum;
  logic [E_W-1:0]     rl_e_max;
  logic [M_X_W-1:0]   rl_m_sum;
  logic [31:0]        rl_out;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        res_data;
  logic [ID_W-1:0]    res_id;

  logic               rst3;
  logic [2:0]         req_valid3;
  logic [2:0]         req_ready3;
  logic [3*E_W-1:0]   req_e_max3;
  logic [3*M_X_W-1:0] req_m_sum3;
  logic [E_W-1:0]     rl_e_max3;
  logic [M_X_W-1:0]   rl_m_sum3;
  logic [31:0]        rl_out3;
  logic               res_valid3;
  logic               res_ready3;
  logic [31:0]        res_data3;
  logic [ID_W-1:0]    res_id3;

  always #5 clk = ~clk;

  assign rl_out  = {rl_e_max, rl_m_sum[23:0]};
  assign rl_out3 = {rl_e_max3, rl_m_sum3[23:0]};

  realign_arb #(.N(N), .E_W(E_W), .M_X_W(M_X_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_e_max(req_e_max), .req_m_sum(req_m_sum),
    .rl_e_max(rl_e_max), .rl_m_sum(rl_m_sum), .rl_out(rl_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  realign_arb #(.N(3), .E_W(E_W), .M_X_W(M_X_W), .ID_W(2)) dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_e_max(req_e_max3), .req_m_sum(req_m_sum3),
    .rl_e_max(rl_e_max3), .rl_m_sum(rl_m_sum3), .rl_out(rl_out3),
    .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_id(res_id3)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setLane(input int i, input logic v, input logic [E_W-1:0] e, input logic [M_X_W-1:0] m);
    req_valid[i]              = v;
    req_e_max[i*E_W +: E_W]   = e;
    req_m_sum[i*M_X_W +: M_X_W] = m;
  endtask

  // Model: in-flight operations in issue order. 'done' marks an operation
  // that has passed the realign unit and sits in the result register.
  typedef struct {
    int              id;
    logic [E_W-1:0]  e;
    logic [M_X_W-1:0] m;
    bit              done;
  } item_t;

  item_t pipe[$];
  int    mptr       = 0;
  int    last_grant = -1;
  bit    hold_on[N];

  always @(negedge clk) begin : model
    bit          head_out;
    bit          had_undone;
    bit          pop;
    bit          advance;
    bit          a_free;
    int          done_left;
    int          g;
    int          c;
    logic [N-1:0] exp_rdy;
    item_t       it;

    last_grant = -1;
    if (rst) begin
      checkOutput("ready_in_reset", 64'(req_ready), 64'(0));
      pipe.delete();
      mptr = 0;
    end else begin
      head_out = (pipe.size() > 0) && pipe[0].done;
      checkOutput("res_valid", 64'(res_valid), 64'(head_out));
      if (head_out) begin
        checkOutput("res_data", 64'(res_data), 64'({pipe[0].e, pipe[0].m[23:0]}));
        checkOutput("res_id", 64'(res_id), 64'(pipe[0].id));
      end
      had_undone = (pipe.size() > 0) && !pipe[pipe.size()-1].done;
      if (had_undone) begin
        checkOutput("rl_e_max", 64'(rl_e_max), 64'(pipe[pipe.size()-1].e));
        checkOutput("rl_m_sum", 64'(rl_m_sum), 64'(pipe[pipe.size()-1].m));
      end else begin
        checkOutput("rl_e_max_idle", 64'(rl_e_max), 64'(0));
        checkOutput("rl_m_sum_idle", 64'(rl_m_sum), 64'(0));
      end

      pop = head_out && res_ready;
      done_left = 0;
      foreach (pipe[j]) if (pipe[j].done) done_left++;
      if (pop) done_left--;
      advance = had_undone && (done_left == 0);
      a_free  = !had_undone || advance;

      g = -1;
      if (a_free) begin
        for (int k = 0; k < N; k++) begin
          c = (mptr + k) % N;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      checkOutput("req_ready", 64'(req_ready), 64'(exp_rdy));

      if (pop) void'(pipe.pop_front());
      if (advance) begin
        it = pipe[pipe.size()-1];
        it.done = 1'b1;
        pipe[pipe.size()-1] = it;
      end
      if (g >= 0) begin
        it.id   = g;
        it.e    = req_e_max[g*E_W +: E_W];
        it.m    = req_m_sum[g*M_X_W +: M_X_W];
        it.done = 1'b0;
        pipe.push_back(it);
        mptr = (g + 1) % N;
        last_grant = g;
      end
    end
  end

  // Advance one clock. A lane that just handshook either drops its request
  // or, if held on, re-offers with a fresh mantissa. In random mode idle
  // lanes may raise new requests and res_ready/rst are randomised.
  task automatic applyStimulus(input bit rnd);
    @(posedge clk);
    #1;
    if (last_grant >= 0) begin
      if (hold_on[last_grant])
        setLane(last_grant, 1'b1, req_e_max[last_grant*E_W +: E_W], 48'({$urandom(), $urandom()}));
      else
        setLane(last_grant, 1'b0, '0, '0);
    end
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(1, 0) == 1))
          setLane(i, 1'b1, 8'($urandom()), 48'({$urandom(), $urandom()}));
      end
      res_ready = ($urandom_range(9, 0) < 7);
      rst       = ($urandom_range(149, 0) == 0);
    end
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      setLane(i, 1'b0, '0, '0);
      hold_on[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    res_ready  = 1'b1;
    req_valid  = '0;
    req_e_max  = '0;
    req_m_sum  = '0;
    rst3       = 1'b1;
    req_valid3 = '0;
    req_e_max3 = '0;
    req_m_sum3 = '0;
    res_ready3 = 1'b1;
    for (int i = 0; i < N; i++) hold_on[i] = 1'b0;

    // Reset values and a single operation from lane 0
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    setLane(0, 1'b1, 8'h80, 48'h0000_00AB_CDEF);
    @(negedge clk);
    checkOutput("reset_res_valid", 64'(res_valid), 64'(0));
    checkOutput("reset_res_data", 64'(res_data), 64'(0));
    checkOutput("reset_res_id", 64'(res_id), 64'(0));
    checkOutput("reset_rl_e_max", 64'(rl_e_max), 64'(0));
    checkOutput("reset_rl_m_sum", 64'(rl_m_sum), 64'(0));
    checkOutput("single_ready", 64'(req_ready), 64'(4'b0001));
    applyStimulus(0);
    @(negedge clk);
    checkOutput("single_rl_e_max", 64'(rl_e_max), 64'(8'h80));
    applyStimulus(0);
    @(negedge clk);
    checkOutput("single_res_valid", 64'(res_valid), 64'(1));
    checkOutput("single_res_data", 64'(res_data), 64'(32'h80AB_CDEF));
    checkOutput("single_res_id", 64'(res_id), 64'(0));
    applyStimulus(0);

    // Round robin with every lane continuously requesting
    resetDut();
    for (int i = 0; i < N; i++) begin
      setLane(i, 1'b1, 8'(i), 48'({$urandom(), $urandom()}));
      hold_on[i] = 1'b1;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 6) checkOutput("rr_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 2) begin
        checkOutput("rr_res_id", 64'(res_id), 64'((c - 2) % 4));
        checkOutput("rr_res_data_e", 64'(res_data[31:24]), 64'((c - 2) % 4));
      end
      applyStimulus(0);
    end

    // Sparse: lane 1 once, then lanes 1 and 3 together
    resetDut();
    setLane(1, 1'b1, 8'h11, 48'h0000_0011_2233);
    @(negedge clk);
    checkOutput("sparse_first", 64'(req_ready), 64'(4'b0010));
    applyStimulus(0);
    setLane(1, 1'b1, 8'h21, 48'h0000_0021_0001);
    setLane(3, 1'b1, 8'h23, 48'h0000_0023_0003);
    @(negedge clk);
    checkOutput("sparse_lane3", 64'(req_ready), 64'(4'b1000));
    applyStimulus(0);
    @(negedge clk);
    checkOutput("sparse_lane1", 64'(req_ready), 64'(4'b0010));
    repeat (4) applyStimulus(0);

    // Backpressure with both stages full
    resetDut();
    res_ready = 1'b0;
    setLane(0, 1'b1, 8'hA0, 48'h1111_2233_4455);
    setLane(1, 1'b1, 8'hA1, 48'h0000_00BB_0001);
    setLane(2, 1'b1, 8'hA2, 48'h0000_00CC_0002);
    @(negedge clk);
    checkOutput("bp_grant0", 64'(req_ready), 64'(4'b0001));
    applyStimulus(0);
    @(negedge clk);
    checkOutput("bp_grant1", 64'(req_ready), 64'(4'b0010));
    applyStimulus(0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_stall_ready", 64'(req_ready), 64'(0));
      checkOutput("bp_stall_id", 64'(res_id), 64'(0));
      checkOutput("bp_stall_data", 64'(res_data), 64'(32'hA033_4455));
      applyStimulus(0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_id0", 64'(res_id), 64'(0));
    checkOutput("bp_resume_grant", 64'(req_ready), 64'(4'b0100));
    applyStimulus(0);
    @(negedge clk);
    checkOutput("bp_release_id1", 64'(res_id), 64'(1));
    applyStimulus(0);
    @(negedge clk);
    checkOutput("bp_release_id2", 64'(res_id), 64'(2));
    repeat (3) applyStimulus(0);

    // Reset mid-flight with both stages full and the pointer at lane 2
    resetDut();
    res_ready = 1'b0;
    setLane(0, 1'b1, 8'hC0, 48'h0000_0000_00C0);
    setLane(1, 1'b1, 8'hC1, 48'h0000_0000_00C1);
    applyStimulus(0);
    applyStimulus(0);
    for (int i = 0; i < N; i++) begin
      setLane(i, 1'b1, 8'hD0 + 8'(i), 48'({$urandom(), $urandom()}));
      hold_on[i] = 1'b1;
    end
    rst = 1'b1;
    applyStimulus(0);
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("rmid_res_valid", 64'(res_valid), 64'(0));
    checkOutput("rmid_first_grant", 64'(req_ready), 64'(4'b0001));
    for (int i = 0; i < N; i++) hold_on[i] = 1'b0;
    repeat (4) applyStimulus(0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) applyStimulus(1);
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) setLane(i, 1'b0, '0, '0);
    repeat (4) applyStimulus(0);

    // Three-lane instance: non-power-of-two wrap
    rst3       = 1'b0;
    req_valid3 = 3'b111;
    req_e_max3 = {8'd2, 8'd1, 8'd0};
    req_m_sum3 = {48'h0000_0000_0302, 48'h0000_0000_0201, 48'h0000_0000_0100};
    res_ready3 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) checkOutput("n3_ready", 64'(req_ready3), 64'(3'b001 << (c % 3)));
      if (c >= 2) begin
        checkOutput("n3_res_id", 64'(res_id3), 64'((c - 2) % 3));
        checkOutput("n3_res_data_e", 64'(res_data3[31:24]), 64'((c - 2) % 3));
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
